// File: rtl/mem_dump_streamer.sv
// Streams a byte-wide data memory out on a valid/ready interface once the processor signals done.
// Optional feature macro: MEM_DUMP_CHECKSUM_EN adds a 16-bit running sum output (checksum_o).
module mem_dump_streamer #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 14,
  parameter int DEPTH     = 10000,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              dump_done_o
`ifdef MEM_DUMP_CHECKSUM_EN
  ,
  output logic [15:0]       checksum_o
`endif
);

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_LAT  = 3'd2,
    S_SEND = 3'd3,
    S_FIN  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                done_q;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                dump_done_q, dump_done_d;
  logic                rd_q, rd_d;
  logic                start_s;
  logic                accept_s;
  logic                last_s;

  assign start_s  = done_i & ~done_q & (state_q == S_IDLE);
  assign accept_s = valid_q & out_ready_i;
  assign last_s   = (index_q == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = start_s ? S_REQ : S_IDLE;
      S_REQ:  state_d = S_LAT;
      S_LAT:  state_d = S_SEND;
      S_SEND: begin
        if (accept_s) begin
          state_d = last_s ? S_FIN : S_REQ;
        end else begin
          state_d = S_SEND;
        end
      end
      // done_i may already be low if it fell mid-dump; then FIN lasts one cycle
      S_FIN:  state_d = done_i ? S_FIN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    index_d     = index_q;
    addr_d      = addr_q;
    data_d      = data_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    dump_done_d = dump_done_q;
    rd_d        = (state_d == S_REQ);
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          index_d     = {IDX_W{1'b0}};
          addr_d      = BASE;
          busy_d      = 1'b1;
          dump_done_d = 1'b0;
        end else begin
          busy_d      = 1'b0;
        end
      end
      S_LAT: begin
        data_d  = mem_data_i;
        valid_d = 1'b1;
      end
      S_SEND: begin
        if (accept_s) begin
          valid_d = 1'b0;
          if (last_s) begin
            busy_d      = 1'b0;
            dump_done_d = 1'b1;
          end else begin
            index_d = index_q + {{(IDX_W-1){1'b0}}, 1'b1};
            addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end else begin
          valid_d = 1'b1;
        end
      end
      S_FIN: begin
        valid_d = 1'b0;
        if (!done_i) begin
          dump_done_d = 1'b0;
        end else begin
          dump_done_d = 1'b1;
        end
      end
      default: begin
        valid_d = valid_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_q     <= {IDX_W{1'b0}};
      addr_q      <= BASE;
      data_q      <= {DATA_W{1'b0}};
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      dump_done_q <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      index_q     <= index_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      dump_done_q <= dump_done_d;
      rd_q        <= rd_d;
    end
  end

  assign mem_rd_o    = rd_q;
  assign mem_addr_o  = addr_q;
  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;
  assign busy_o      = busy_q;
  assign dump_done_o = dump_done_q;

`ifdef MEM_DUMP_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  // Sum of accepted bytes, restarted on every start edge
  always_comb begin
    csum_d = csum_q;
    if (start_s) begin
      csum_d = 16'h0000;
    end else if ((state_q == S_SEND) && accept_s) begin
      csum_d = csum_q + 16'(data_q);
    end else begin
      csum_d = csum_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= 16'h0000;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum_o = csum_q;
`endif

endmodule
